// File: rtl/cache_ctrl_2way_if.sv
// Bus bundle between the MEM stage, the 2-way cache controller and the SRAM controller.
// The slave modport is the cache's view; the master modport is the surrounding system
// (MEM stage requests plus SRAM controller responses).
interface cache_ctrl_2way_if;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        flush;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_adr;
    logic [31:0] sram_wdata;
    logic        sram_read;
    logic        sram_write;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  adr, wdata, MEM_R_EN, MEM_W_EN, flush, sram_rdata, sram_ready,
        output rdata, ready, sram_adr, sram_wdata, sram_read, sram_write
    );

    modport master (
        output adr, wdata, MEM_R_EN, MEM_W_EN, flush, sram_rdata, sram_ready,
        input  rdata, ready, sram_adr, sram_wdata, sram_read, sram_write
    );
endinterface

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative, write-through, no-write-allocate cache controller.
// Lines are 64 bits (two words) and are filled by a single SRAM handshake.
// Each set keeps one LRU bit naming the way to evict next; hit/miss counters saturate.
module cache_ctrl_2way #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 10,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_ctrl_2way_if.slave     bus,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);
    localparam int SETS = 2 ** SET_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WR, RESP} state_t;

    state_t              state_q, state_d;
    logic                sram_read_q, sram_read_d;
    logic                sram_write_q, sram_write_d;
    logic [31:0]         sram_adr_q, sram_adr_d;
    logic [31:0]         sram_wdata_q, sram_wdata_d;
    logic [SETS-1:0]     valid0_q, valid0_d;
    logic [SETS-1:0]     valid1_q, valid1_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [TAG_BITS-1:0] tag0_q  [SETS];
    logic [TAG_BITS-1:0] tag1_q  [SETS];
    logic [63:0]         data0_q [SETS];
    logic [63:0]         data1_q [SETS];

    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                word_sel;
    logic                hit0, hit1, hit;
    logic [63:0]         hit_line;
    logic [31:0]         hit_word;
    logic                fill_we;
    logic                wr_we;
    logic                victim;
    logic                ready;

    assign idx      = bus.adr[SET_BITS+2:3];
    assign tag      = bus.adr[SET_BITS+TAG_BITS+2:SET_BITS+3];
    assign word_sel = bus.adr[2];
    assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit      = hit0 || hit1;
    assign hit_line = hit1 ? data1_q[idx] : data0_q[idx];
    assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];

    // Handshake back to the MEM stage: hits complete in the same cycle, misses and stores in RESP.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush)
                    ready = ~(bus.MEM_R_EN | bus.MEM_W_EN);
                else if (bus.MEM_W_EN)
                    ready = 1'b0;
                else if (bus.MEM_R_EN)
                    ready = hit;
                else
                    ready = 1'b1;
            end
            RESP:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign bus.ready      = ready;
    assign bus.rdata      = (ready && bus.MEM_R_EN && hit) ? hit_word : 32'h0;
    assign bus.sram_read  = sram_read_q;
    assign bus.sram_write = sram_write_q;
    assign bus.sram_adr   = sram_adr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

    // Next-state, SRAM request, valid/LRU and counter updates for the controller FSM.
    always_comb begin
        state_d      = state_q;
        sram_read_d  = sram_read_q;
        sram_write_d = sram_write_q;
        sram_adr_d   = sram_adr_q;
        sram_wdata_d = sram_wdata_q;
        valid0_d     = valid0_q;
        valid1_d     = valid1_q;
        lru_d        = lru_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        fill_we      = 1'b0;
        wr_we        = 1'b0;
        victim       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid0_d = '0;
                    valid1_d = '0;
                    lru_d    = '0;
                end else if (bus.MEM_W_EN) begin
                    state_d      = WR;
                    sram_write_d = 1'b1;
                    sram_adr_d   = bus.adr & 32'hFFFF_FFFC;
                    sram_wdata_d = bus.wdata;
                end else if (bus.MEM_R_EN) begin
                    if (hit) begin
                        lru_d[idx] = ~hit1;
                        if (hit_cnt_q != '1)
                            hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        state_d     = FILL;
                        sram_read_d = 1'b1;
                        sram_adr_d  = bus.adr & 32'hFFFF_FFF8;
                    end
                end
            end
            FILL: begin
                if (bus.sram_ready) begin
                    if (!valid0_q[idx])
                        victim = 1'b0;
                    else if (!valid1_q[idx])
                        victim = 1'b1;
                    else
                        victim = lru_q[idx];
                    if (victim)
                        valid1_d[idx] = 1'b1;
                    else
                        valid0_d[idx] = 1'b1;
                    lru_d[idx] = ~victim;
                    fill_we    = 1'b1;
                    if (miss_cnt_q != '1)
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    state_d     = RESP;
                    sram_read_d = 1'b0;
                    sram_adr_d  = 32'h0;
                end
            end
            WR: begin
                if (bus.sram_ready) begin
                    if (hit) begin
                        wr_we      = 1'b1;
                        lru_d[idx] = ~hit1;
                    end
                    state_d      = RESP;
                    sram_write_d = 1'b0;
                    sram_adr_d   = 32'h0;
                    sram_wdata_d = 32'h0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, registered SRAM request outputs, valid/LRU bits and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sram_read_q  <= 1'b0;
            sram_write_q <= 1'b0;
            sram_adr_q   <= 32'h0;
            sram_wdata_q <= 32'h0;
            valid0_q     <= '0;
            valid1_q     <= '0;
            lru_q        <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sram_read_q  <= sram_read_d;
            sram_write_q <= sram_write_d;
            sram_adr_q   <= sram_adr_d;
            sram_wdata_q <= sram_wdata_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            lru_q        <= lru_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag and data storage; contents only matter once the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            if (victim) begin
                tag1_q[idx]  <= tag;
                data1_q[idx] <= bus.sram_rdata;
            end else begin
                tag0_q[idx]  <= tag;
                data0_q[idx] <= bus.sram_rdata;
            end
        end else if (wr_we) begin
            if (hit1) begin
                if (word_sel)
                    data1_q[idx][63:32] <= bus.wdata;
                else
                    data1_q[idx][31:0] <= bus.wdata;
            end else begin
                if (word_sel)
                    data0_q[idx][63:32] <= bus.wdata;
                else
                    data0_q[idx][31:0] <= bus.wdata;
            end
        end
    end
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench for cache_ctrl_2way: a reference cache model predicts each
// transaction, pushes the expectation to a scoreboard and compares on completion.
module tb_cache_ctrl_2way;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        bit          exp_miss;
        logic [31:0] exp_sram_adr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];

    bit          m_valid [2][64];
    logic [9:0]  m_tag   [2][64];
    bit          m_lru   [64];
    int          m_hits;
    int          m_misses;

    logic [31:0] mem [logic [31:0]];
    bit          sram_hold = 1'b0;
    int          sram_lat  = 0;
    int          wait_cnt  = 0;

    cache_ctrl_2way_if bus();

    cache_ctrl_2way #(
        .SET_BITS(6),
        .TAG_BITS(10),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return {a[15:0] ^ 16'hC3C3, a[15:0]};
    endfunction

    function automatic int m_find(input logic [31:0] a);
        logic [5:0] ix;
        ix = a[8:3];
        for (int w = 0; w < 2; w++)
            if (m_valid[w][ix] && m_tag[w][ix] == a[18:9])
                return w;
        return -1;
    endfunction

    task automatic m_clear_lines();
        for (int s = 0; s < 64; s++) begin
            m_valid[0][s] = 1'b0;
            m_valid[1][s] = 1'b0;
            m_lru[s]      = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM controller model: answers each request after 0-2 extra cycles with a one-cycle ready pulse.
    initial begin
        bus.sram_ready = 1'b0;
        bus.sram_rdata = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.sram_ready) begin
                bus.sram_ready = 1'b0;
                bus.sram_rdata = 64'h0;
            end else if (rst || sram_hold) begin
                wait_cnt = 0;
            end else if (bus.sram_read || bus.sram_write) begin
                if (wait_cnt < sram_lat) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    if (bus.sram_write)
                        mem[bus.sram_adr] = bus.sram_wdata;
                    else
                        bus.sram_rdata = {sram_word(bus.sram_adr + 32'd4), sram_word(bus.sram_adr)};
                    bus.sram_ready = 1'b1;
                    sram_lat = $urandom_range(0, 2);
                end
            end
        end
    end

    // One MEM-stage request: predict, push, drive, wait for ready, pop and compare.
    task automatic applyStimulus(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        exp_t        got;
        int          way;
        int          victim;
        int          cycles;
        bit          done;
        bit          saw_rd;
        bit          saw_wr;
        logic [31:0] obs_adr;
        logic [31:0] obs_wd;
        logic [31:0] obs_rd;
        logic [5:0]  ix;

        ix          = a[8:3];
        e.is_wr     = is_wr;
        e.addr      = a;
        e.exp_wdata = d;
        e.exp_rdata = sram_word({a[31:2], 2'b00});
        e.exp_miss  = 1'b0;
        way         = m_find(a);
        if (is_wr) begin
            e.exp_sram_adr = {a[31:2], 2'b00};
            if (way >= 0)
                m_lru[ix] = (way == 0);
        end else if (way >= 0) begin
            e.exp_sram_adr = 32'h0;
            m_lru[ix]      = (way == 0);
            if (m_hits < CNT_MAX)
                m_hits++;
        end else begin
            e.exp_miss     = 1'b1;
            e.exp_sram_adr = {a[31:3], 3'b000};
            if (!m_valid[0][ix])
                victim = 0;
            else if (!m_valid[1][ix])
                victim = 1;
            else
                victim = int'(m_lru[ix]);
            m_valid[victim][ix] = 1'b1;
            m_tag[victim][ix]   = a[18:9];
            m_lru[ix]           = (victim == 0);
            if (m_misses < CNT_MAX)
                m_misses++;
        end
        sb_q.push_back(e);

        bus.adr      = a;
        bus.wdata    = d;
        bus.MEM_W_EN = is_wr;
        bus.MEM_R_EN = !is_wr;

        cycles  = 0;
        done    = 1'b0;
        saw_rd  = 1'b0;
        saw_wr  = 1'b0;
        obs_adr = 32'h0;
        obs_wd  = 32'h0;
        obs_rd  = 32'h0;
        while (!done) begin
            @(negedge clk);
            if (bus.sram_read) begin
                saw_rd  = 1'b1;
                obs_adr = bus.sram_adr;
            end
            if (bus.sram_write) begin
                saw_wr  = 1'b1;
                obs_adr = bus.sram_adr;
                obs_wd  = bus.sram_wdata;
            end
            if (bus.ready) begin
                done   = 1'b1;
                obs_rd = bus.rdata;
            end else if (cycles >= 40) begin
                checkOutput("ready_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end else begin
                cycles++;
            end
        end
        @(posedge clk);
        #1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;

        got = sb_q.pop_front();
        if (got.is_wr) begin
            checkOutput("wr_sram_write", saw_wr, 1'b1);
            checkOutput("wr_sram_adr", obs_adr, got.exp_sram_adr);
            checkOutput("wr_sram_wdata", obs_wd, got.exp_wdata);
        end else begin
            checkOutput("rd_sram_read", saw_rd, got.exp_miss);
            if (got.exp_miss)
                checkOutput("rd_fill_adr", obs_adr, got.exp_sram_adr);
            else
                checkOutput("rd_hit_latency", cycles, 0);
            checkOutput("rd_rdata", obs_rd, got.exp_rdata);
        end
        checkOutput("hit_cnt", hit_cnt, m_hits);
        checkOutput("miss_cnt", miss_cnt, m_misses);
    endtask

    initial begin
        int          cycles;
        logic [31:0] a;

        rst          = 1'b1;
        bus.adr      = 32'h0;
        bus.wdata    = 32'h0;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.flush    = 1'b0;
        m_clear_lines();
        m_hits   = 0;
        m_misses = 0;
        mem[32'h0000_0100] = 32'hAAAA_AAAA;
        mem[32'h0000_0104] = 32'hBBBB_BBBB;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_ready", bus.ready, 1'b1);
        checkOutput("reset_rdata", bus.rdata, 32'h0);
        checkOutput("reset_sram_read", bus.sram_read, 1'b0);
        checkOutput("reset_sram_write", bus.sram_write, 1'b0);
        checkOutput("reset_hit_cnt", hit_cnt, 0);
        checkOutput("reset_miss_cnt", miss_cnt, 0);

        $display("[TB] fill, hit and LRU eviction in one set");
        applyStimulus(1'b0, 32'h0000_0104, 32'h0);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);
        applyStimulus(1'b0, 32'h0001_0100, 32'h0);
        applyStimulus(1'b0, 32'h0002_0100, 32'h0);
        applyStimulus(1'b0, 32'h0001_0100, 32'h0);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);

        $display("[TB] write-through hit and no-allocate miss");
        applyStimulus(1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0000_0104, 32'h0);
        applyStimulus(1'b1, 32'h0000_0300, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0000_0300, 32'h0);

        $display("[TB] mixed traffic over two sets");
        for (int i = 0; i < 24; i++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 1)) << 3)
              | (32'($urandom_range(0, 1)) << 2);
            applyStimulus($urandom_range(0, 3) == 0, a, $urandom);
        end

        $display("[TB] counter saturation");
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 32'h0000_0104, 32'h0);

        $display("[TB] flush");
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        m_clear_lines();
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);

        $display("[TB] reset during fill");
        sram_hold    = 1'b1;
        bus.adr      = 32'h0000_5000;
        bus.MEM_R_EN = 1'b1;
        cycles       = 0;
        while (!bus.sram_read && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("fill_entered", bus.sram_read, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        bus.MEM_R_EN = 1'b0;
        #1;
        checkOutput("rst_sram_read", bus.sram_read, 1'b0);
        checkOutput("rst_ready", bus.ready, 1'b1);
        checkOutput("rst_miss_cnt", miss_cnt, 0);
        checkOutput("rst_hit_cnt", hit_cnt, 0);
        m_clear_lines();
        m_hits   = 0;
        m_misses = 0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sram_hold = 1'b0;
        applyStimulus(1'b0, 32'h0000_5000, 32'h0);
        applyStimulus(1'b0, 32'h0000_5004, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
